tff_counter: RTL and testbench
==============================

# tff_counter

Synchronous modulo-N up/down counter built as a bank of toggle stages, sitting directly downstream of the T flip-flop cell. Each bit is one `tff_cell` instance, and the counter logic's only job is to compute the per-bit toggle vector every cycle. Typical uses are clock-enable division and event counting. It also provides a terminal-count flag and a registered wrap pulse for chaining cascaded counters.

## Interface
Parameters:
- `WIDTH`, 4: counter width in bits.
- `MODULUS`, 10: count range is 0..MODULUS-1. Legal values are 2 ≤ MODULUS ≤ 2^WIDTH; an illegal value is an elaboration error.

Ports:
- `clk`  input  1  rising-edge clock; the block's only clock.
- `reset`  input  1  asynchronous, active-low reset.
- `en`  input  1  count enable.
- `up`  input  1  direction: 1 = increment, 0 = decrement (effective only with `TFF_COUNTER_DOWN_EN`).
- `load`  input  1  synchronous load strobe.
- `load_val`  input  WIDTH  value to load.
- `q`  output  WIDTH  current count.
- `tc`  output  1  terminal-count flag (combinational).
- `wrap`  output  1  registered one-cycle wrap pulse.

## Operation
- Per-cycle next-state priority: `load` > `en` > hold.
- **Load:** `q` takes `load_val`. If `load_val` ≥ MODULUS, `q` takes MODULUS-1 instead (clamp). A load never asserts `wrap`.
- **Up count** (`en`=1, `up`=1):
  - `q` = MODULUS-1 goes to 0.
  - Any other value goes to `q`+1.
- **Down count** (`en`=1, `up`=0, macro defined):
  - `q` = 0 goes to MODULUS-1.
  - Any other value goes to `q`-1.
- **Hold:** when `en`=0 and `load`=0, every toggle bit is 0 and `q` is unchanged.
- **Toggle vector:** `t` = `q` XOR `next`, with one bit per `tff_cell`. Every state change is produced only by toggling cells; there is no direct D path.
- **`tc`** = `en` AND NOT `load` AND (`q` == terminal value). The terminal value is MODULUS-1 when counting up and 0 when counting down. This means `tc` is high exactly in the cycle whose clock edge causes a wrap.
- **`wrap`** is a register loaded with `tc`, so it is high for exactly one cycle after each wrap.
- **Arithmetic:** all arithmetic is WIDTH bits, unsigned. For MODULUS = 2^WIDTH the wrap is the natural binary overflow, and the result must be identical to the explicit compare.
- **`up` changes mid-count:** the new direction takes effect on the next edge; there is no reset of the count.

## Timing
- **Reset values:** while `reset`=0, `q` = 0, `wrap` = 0, and `tc` = 0 (forced low during reset). Reset is asserted asynchronously and `q` clears without waiting for a clock.
- **Latency:** 1 cycle from `en`/`load` being sampled to `q` updating. `wrap` is 1 cycle after the wrapping edge.
- **Reset mid-count:** the count is abandoned immediately. The first edge after `reset` deasserts operates from `q` = 0; if `en`=1 at that edge, `q` becomes 1 when counting up.
- **`load` and `en` together:** `load` wins. `tc` is 0 and no `wrap` follows.
- **Load equal to terminal value:** `q` = MODULUS-1, and the following enabled up-count edge wraps normally.
- Inputs must be synchronous to `clk`; there is no internal synchronizer.

## Configuration
- **`TFF_COUNTER_DOWN_EN` defined:** bidirectional counting as above, with the terminal value selected by `up`.
- **`TFF_COUNTER_DOWN_EN` not defined:**
  - Up-count only; `up` is ignored and the decrement logic is not built.
  - The terminal value is always MODULUS-1.
  - The port list is unchanged.

## Structure
- **Shared package `tff_counter_pkg`:**
  - Direction constants `DIR_UP` = 1 and `DIR_DOWN` = 0.
  - A function `clamp_load(val, modulus)` implementing the clamp rule.
  - A function `mod_legal(width, modulus)` used by the elaboration check.
- **Sub-module `tff_cell`:**
  - Ports: `clk`, `reset` (asynchronous, active-low), `t`, and `q`.
  - Behaviour: `q` toggles on the rising edge when `t`=1 and is cleared by reset.
  - `tff_counter` instantiates WIDTH of them through a generate loop.
- The combinational next-state, toggle vector and `tc` logic, plus the `wrap` register, live in `tff_counter` itself.

## Test plan
- **Reset:** WIDTH=4, MODULUS=10. Pulse `reset` low mid-cycle → `q`=0 and `wrap`=0 immediately, without a clock edge.
- **Up-count wrap:** `en`=1, `up`=1 for 12 cycles from 0 → `q` steps 0..9, 0, 1. `tc` is high only while `q`=9. `wrap` is high exactly one cycle, the cycle after 9→0.
- **Down-count wrap (macro defined):** start `q`=1, `up`=0, `en`=1 → `q` steps 1, 0, 9, 8. `wrap` pulses once, the cycle after 0→9. With the macro undefined, the same stimulus counts up: 1, 2, 3.
- **Load clamp and priority:**
  - `load`=1 with `load_val`=13 → `q`=9.
  - `load`=1 and `en`=1 together with `load_val`=9 → `q`=9, `tc`=0, no `wrap`.
- **Hold and reset mid-count:**
  - With `q`=5, `en`=0 for 3 cycles → `q` holds at 5.
  - Assert `reset` at `q`=7 → `q`=0 immediately.
  - Release `reset` with `en`=1 → `q`=1 after the first edge.
- **Power-of-two modulus:** MODULUS=16, up-count → 15→0 wrap with `wrap` pulsing once per 16 cycles.

Source files
------------

// File: rtl/tff_counter_pkg.sv
// Shared definitions for the toggle-stage modulo-N counter.
//   DIR_UP / DIR_DOWN : encodings of the 'up' direction input
//   clamp_load()      : saturate an out-of-range load value to MODULUS-1
//   mod_legal()       : elaboration-time legality check of WIDTH/MODULUS
package tff_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    function automatic int unsigned clamp_load(input int unsigned val,
                                               input int unsigned modulus);
        return (val >= modulus) ? modulus - 1 : val;
    endfunction

    // Widths above 32 are rejected because the load path goes through int unsigned.
    function automatic bit mod_legal(input int unsigned     width,
                                     input longint unsigned modulus);
        return (width >= 1) && (width <= 32) && (modulus >= 2) &&
               (modulus <= (64'd1 << width));
    endfunction

endpackage

// File: rtl/tff_cell.sv
// Single T flip-flop stage.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous active-low clear
//   t     : toggle request, q inverts on the next rising edge when high
//   q     : stored bit
module tff_cell (
    input  logic clk,
    input  logic reset,
    input  logic t,
    output logic q
);

    logic q_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q_q <= 1'b0;
        end else if (t) begin
            q_q <= ~q_q;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/tff_counter.sv
// Modulo-MODULUS counter built from WIDTH tff_cell stages. Only the per-bit
// toggle vector is computed here; every state change happens by toggling cells.
// Optional feature macro: TFF_COUNTER_DOWN_EN enables down counting via 'up'.
// Ports:
//   clk      : rising-edge clock
//   reset    : asynchronous active-low reset
//   en       : count enable
//   up       : 1 = increment, 0 = decrement (only with TFF_COUNTER_DOWN_EN)
//   load     : synchronous load strobe, has priority over en
//   load_val : value to load, clamped to MODULUS-1
//   q        : current count
//   tc       : terminal-count flag, high in the cycle whose edge wraps
//   wrap     : registered one-cycle pulse following each wrap
module tff_counter
    import tff_counter_pkg::*;
#(
    parameter int unsigned WIDTH   = 4,
    parameter int unsigned MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    if (!mod_legal(WIDTH, 64'(MODULUS))) begin : g_bad_modulus
        $error("tff_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    localparam logic [WIDTH-1:0] TermUp = WIDTH'(MODULUS - 1);

    logic [WIDTH-1:0] next_q;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] term;
    logic [WIDTH-1:0] load_clamped;
    logic             wrap_q;

    assign load_clamped = WIDTH'(clamp_load(32'(load_val), MODULUS));

`ifndef TFF_COUNTER_DOWN_EN
    logic unused_up;
    assign unused_up = up;
`endif

    always_comb begin
        term = TermUp;
`ifdef TFF_COUNTER_DOWN_EN
        if (up == DIR_DOWN) begin
            term = '0;
        end
`endif

        next_q = q;
        if (load) begin
            next_q = load_clamped;
        end else if (en) begin
`ifdef TFF_COUNTER_DOWN_EN
            if (up == DIR_DOWN) begin
                next_q = (q == '0) ? TermUp : q - 1'b1;
            end else begin
                next_q = (q == TermUp) ? '0 : q + 1'b1;
            end
`else
            // For MODULUS == 2**WIDTH the explicit compare and the binary
            // overflow produce the same result.
            next_q = (q == TermUp) ? '0 : q + 1'b1;
`endif
        end

        t = q ^ next_q;

        // Gated by reset so the flag is low while the counter is held clear.
        tc = reset & en & ~load & (q == term);
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        tff_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .t     (t[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wrap_q <= 1'b0;
        end else begin
            wrap_q <= tc;
        end
    end

    assign wrap = wrap_q;

endmodule

// File: tb/tb_tff_counter.sv
module tb_tff_counter;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b1;
    logic       up = 1'b1;
    logic       load = 1'b0;
    logic [3:0] load_val = 4'd0;

    logic [3:0] q, q16;
    logic       tc, tc16, wrap, wrap16;

    tff_counter #(.WIDTH(4), .MODULUS(10)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .tc       (tc),
        .wrap     (wrap)
    );

    tff_counter #(.WIDTH(4), .MODULUS(16)) dut16 (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q16),
        .tc       (tc16),
        .wrap     (wrap16)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q;
        logic       wrap;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] m_q = 4'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] model_next(input logic [3:0] cur, input logic e, input logic u,
                                              input logic l, input logic [3:0] v);
        if (l) return (v >= 4'd10) ? 4'd9 : v;
        if (!e) return cur;
`ifdef TFF_COUNTER_DOWN_EN
        if (!u) return (cur == 4'd0) ? 4'd9 : cur - 4'd1;
`endif
        return (cur == 4'd9) ? 4'd0 : cur + 4'd1;
    endfunction

    function automatic logic model_tc(input logic [3:0] cur, input logic e, input logic u,
                                      input logic l);
        logic [3:0] term;
        term = 4'd9;
`ifdef TFF_COUNTER_DOWN_EN
        if (!u) term = 4'd0;
`endif
        return e && !l && (cur == term);
    endfunction

    // Called at a falling edge: drive, check tc, push expectation, clock, pop and compare.
    task automatic cycle(input logic e, input logic u, input logic l, input logic [3:0] v,
                         input string tag);
        exp_t x;
        logic tc_exp;
        en = e;
        up = u;
        load = l;
        load_val = v;
        #1;
        tc_exp = model_tc(m_q, e, u, l);
        check({tag, ".tc"}, 32'(tc), 32'(tc_exp));
        m_q = model_next(m_q, e, u, l, v);
        x.q = m_q;
        x.wrap = tc_exp;
        sb.push_back(x);
        @(posedge clk);
        @(negedge clk);
        x = sb.pop_front();
        check({tag, ".q"}, 32'(q), 32'(x.q));
        check({tag, ".wrap"}, 32'(wrap), 32'(x.wrap));
    endtask

    // Asynchronous reset pulse in the middle of a low clock phase.
    task automatic reset_pulse(input string tag);
        en = 1'b1;
        up = 1'b0;
        load = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        check({tag, ".q"}, 32'(q), 32'd0);
        check({tag, ".wrap"}, 32'(wrap), 32'd0);
        check({tag, ".tc"}, 32'(tc), 32'd0);
        check({tag, ".q16"}, 32'(q16), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_q = 4'd0;
    endtask

    initial begin
        int nwrap;

        // Reset state from time zero, with en high.
        #3;
        check("rst.q", 32'(q), 32'd0);
        check("rst.wrap", 32'(wrap), 32'd0);
        check("rst.tc", 32'(tc), 32'd0);
        @(negedge clk);
        reset = 1'b1;

        // Up count 0..9, 0, 1.
        for (int i = 0; i < 12; i++) begin
            check("up.seq_q", 32'(q), 32'(i % 10));
            check("up.seq_wrap", 32'(wrap), 32'(i == 10));
            cycle(1'b1, 1'b1, 1'b0, 4'd0, "up");
        end

        // Load and en together at the terminal value: load wins, no wrap.
        cycle(1'b1, 1'b1, 1'b1, 4'd9, "ld_en");
        check("ld_en.q9", 32'(q), 32'd9);
        check("ld_en.nowrap", 32'(wrap), 32'd0);
        cycle(1'b1, 1'b1, 1'b0, 4'd0, "ld_wrap");
        check("ld_wrap.q0", 32'(q), 32'd0);
        check("ld_wrap.pulse", 32'(wrap), 32'd1);

        // Reset while wrap is high clears it without a clock edge.
        reset_pulse("rst_wrap");

        // Reset at q=7, then release with en=1.
        cycle(1'b0, 1'b1, 1'b1, 4'd7, "ld7");
        check("ld7.q", 32'(q), 32'd7);
        reset_pulse("rst_mid");
        cycle(1'b1, 1'b1, 1'b0, 4'd0, "post_rst");
        check("post_rst.q1", 32'(q), 32'd1);

        // Load clamp.
        cycle(1'b0, 1'b1, 1'b1, 4'd13, "clamp");
        check("clamp.q9", 32'(q), 32'd9);
        cycle(1'b0, 1'b1, 1'b1, 4'd15, "clamp15");
        check("clamp15.q9", 32'(q), 32'd9);

        // Hold.
        cycle(1'b0, 1'b1, 1'b1, 4'd5, "ld5");
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, 1'b0, 4'd0, "hold");
            check("hold.q5", 32'(q), 32'd5);
        end

        // Direction: from 1 with up=0.
        cycle(1'b0, 1'b1, 1'b1, 4'd1, "ld1");
        for (int i = 0; i < 4; i++) begin
`ifdef TFF_COUNTER_DOWN_EN
            logic [3:0] dseq [4] = '{4'd1, 4'd0, 4'd9, 4'd8};
            check("down.seq_q", 32'(q), 32'(dseq[i]));
            check("down.seq_wrap", 32'(wrap), 32'(i == 2));
`else
            check("down.seq_q", 32'(q), 32'(i + 1));
            check("down.seq_wrap", 32'(wrap), 32'd0);
`endif
            cycle(1'b1, 1'b0, 1'b0, 4'd0, "down");
        end

        // Power-of-two modulus on the second instance.
        reset_pulse("rst16");
        nwrap = 0;
        for (int i = 0; i < 33; i++) begin
            check("p2.q16", 32'(q16), 32'(i % 16));
            check("p2.wrap16", 32'(wrap16), 32'((i == 16) || (i == 32)));
            if (wrap16) nwrap++;
            cycle(1'b1, 1'b1, 1'b0, 4'd0, "p2");
        end
        check("p2.wraps", 32'(nwrap), 32'd2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
